// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, RUN/HALT control and a
// saturating debug counter of IF/ID hold cycles.
module if_fetch_stage #(
  parameter int                    PC_W      = 16,
  parameter int                    INSTR_W   = 16,
  parameter int                    PC_INC    = 2,
  parameter logic [PC_W-1:0]       RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = '0,
  parameter logic [3:0]            HALT_OP   = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               ifid_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic [3:0]         ifid_op1,
  output logic [3:0]         ifid_op2,
  output logic               halted,
  output logic [15:0]        stall_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc;
  logic [PC_W-1:0]    r_ifid_pc_next;
  logic               r_ifid_valid;
  logic [15:0]        r_stall_count;

  logic [PC_W-1:0]    w_pc_inc;
  logic               w_is_halt;

  // Addition naturally wraps modulo 2^PC_W.
  assign w_pc_inc  = r_pc + PC_W'(PC_INC);
  assign w_is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_ifid_instr   <= NOP_INSTR;
      r_ifid_pc      <= '0;
      r_ifid_pc_next <= '0;
      r_ifid_valid   <= 1'b0;
    end else if (branch_taken) begin
      // The redirecting branch is older than anything held by a stall, so it wins.
      r_state        <= ST_RUN;
      r_pc           <= branch_target;
      r_ifid_instr   <= NOP_INSTR;
      r_ifid_pc      <= '0;
      r_ifid_pc_next <= '0;
      r_ifid_valid   <= 1'b0;
    end else if (r_state == ST_HALT) begin
      // PC frozen; any IF/ID advance injects a bubble with zeroed PC fields.
      if (ifid_write) begin
        r_ifid_instr   <= NOP_INSTR;
        r_ifid_pc      <= '0;
        r_ifid_pc_next <= '0;
        r_ifid_valid   <= 1'b0;
      end
    end else begin
      if (pc_write) begin
        r_pc <= w_pc_inc;
      end
      if (ifid_write) begin
        r_ifid_instr   <= imem_rdata;
        r_ifid_pc      <= r_pc;
        r_ifid_pc_next <= w_pc_inc;
        r_ifid_valid   <= 1'b1;
        if (w_is_halt) begin
          r_state <= ST_HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (!branch_taken && !ifid_write && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign imem_addr    = r_pc;
  assign ifid_instr   = r_ifid_instr;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_pc_next = r_ifid_pc_next;
  assign ifid_valid   = r_ifid_valid;
  assign ifid_op1     = r_ifid_instr[7:4];
  assign ifid_op2     = r_ifid_instr[3:0];
  assign halted       = (r_state == ST_HALT);
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stimulus pushes hand-computed expected
// post-edge state, a negedge monitor pops and compares against the outputs.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        ifid_write;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic        ifid_valid;
  logic [3:0]  ifid_op1;
  logic [3:0]  ifid_op2;
  logic        halted;
  logic [15:0] stall_count;

  logic        halt_at_10;
  int          checks;
  int          errors;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] inext;
    logic        v;
    logic        h;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_next  (ifid_pc_next),
    .ifid_valid    (ifid_valid),
    .ifid_op1      (ifid_op1),
    .ifid_op2      (ifid_op2),
    .halted        (halted),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-derived memory image; address 10 can be switched to a halt word.
  always_comb begin
    imem_rdata = {4'h1, imem_addr[11:0]};
    if (halt_at_10 && imem_addr == 16'd10) imem_rdata = 16'hF123;
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp("imem_addr",    imem_addr,             mon_e.pc);
      cmp("ifid_instr",   ifid_instr,            mon_e.instr);
      cmp("ifid_pc",      ifid_pc,               mon_e.ipc);
      cmp("ifid_pc_next", ifid_pc_next,          mon_e.inext);
      cmp("ifid_valid",   {15'd0, ifid_valid},   {15'd0, mon_e.v});
      cmp("ifid_op1",     {12'd0, ifid_op1},     {12'd0, mon_e.instr[7:4]});
      cmp("ifid_op2",     {12'd0, ifid_op2},     {12'd0, mon_e.instr[3:0]});
      cmp("halted",       {15'd0, halted},       {15'd0, mon_e.h});
      cmp("stall_count",  stall_count,           mon_e.sc);
      $display("check t=%0t addr=%h instr=%h pc=%h next=%h v=%0b h=%0b sc=%h",
               $time, imem_addr, ifid_instr, ifid_pc, ifid_pc_next, ifid_valid, halted, stall_count);
    end
  end

  // One clock edge with the currently driven inputs; optionally queue the expected state.
  task automatic step(input logic chk, input logic [15:0] pc, input logic [15:0] instr,
                      input logic [15:0] ipc, input logic [15:0] inext,
                      input logic v, input logic h, input logic [15:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    if (chk) begin
      e.pc = pc; e.instr = instr; e.ipc = ipc; e.inext = inext;
      e.v = v; e.h = h; e.sc = sc;
      exp_q.push_back(e);
    end
  endtask

  task automatic ctl(input logic r, input logic pw, input logic iw, input logic bt, input logic [15:0] tgt);
    rst = r; pc_write = pw; ifid_write = iw; branch_taken = bt; branch_target = tgt;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    halt_at_10 = 1'b0;
    ctl(1, 1, 1, 0, 16'h0000);

    // Reset
    step(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
    step(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);

    // Free-run fetch
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1, 0, 16'd0);
    step(1, 16'h0004, 16'h1002, 16'h0002, 16'h0004, 1, 0, 16'd0);
    step(1, 16'h0006, 16'h1004, 16'h0004, 16'h0006, 1, 0, 16'd0);
    step(1, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1, 0, 16'd0);

    // Load-use stall for 2 cycles, then release
    ctl(0, 0, 0, 0, 16'h0000);
    step(1, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1, 0, 16'd1);
    step(1, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1, 0, 16'd2);
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h000A, 16'h1008, 16'h0008, 16'h000A, 1, 0, 16'd2);

    // Branch during stall: flush wins, not counted
    ctl(0, 0, 0, 1, 16'h0040);
    step(1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd2);
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h0042, 16'h1040, 16'h0040, 16'h0042, 1, 0, 16'd2);

    // Mismatched controls
    ctl(0, 1, 0, 0, 16'h0000);
    step(1, 16'h0044, 16'h1040, 16'h0040, 16'h0042, 1, 0, 16'd3);
    ctl(0, 0, 1, 0, 16'h0000);
    step(1, 16'h0044, 16'h1044, 16'h0044, 16'h0046, 1, 0, 16'd3);

    // PC wrap
    ctl(0, 1, 1, 1, 16'hFFFE);
    step(1, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd3);
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h0000, 16'h1FFE, 16'hFFFE, 16'h0000, 1, 0, 16'd3);
    step(1, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1, 0, 16'd3);
    step(1, 16'h0004, 16'h1002, 16'h0002, 16'h0004, 1, 0, 16'd3);
    step(1, 16'h0006, 16'h1004, 16'h0004, 16'h0006, 1, 0, 16'd3);
    step(1, 16'h0008, 16'h1006, 16'h0006, 16'h0008, 1, 0, 16'd3);
    step(1, 16'h000A, 16'h1008, 16'h0008, 16'h000A, 1, 0, 16'd3);

    // Halt instruction at address 10
    halt_at_10 = 1'b1;
    step(1, 16'h000C, 16'hF123, 16'h000A, 16'h000C, 1, 1, 16'd3);
    step(1, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd3);
    ctl(0, 1, 0, 0, 16'h0000);
    step(1, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd4);
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'd4);
    ctl(0, 1, 1, 1, 16'h0020);
    step(1, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd4);
    halt_at_10 = 1'b0;
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h0022, 16'h1020, 16'h0020, 16'h0022, 1, 0, 16'd4);

    // Drive stall_count to saturation, then confirm it sticks
    ctl(0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 65530; i++) begin
      step(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
    end
    step(1, 16'h0022, 16'h1020, 16'h0020, 16'h0022, 1, 0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h0022, 16'h1020, 16'h0020, 16'h0022, 1, 0, 16'hFFFF);
    end

    // Reset mid-stall with a pending branch
    ctl(1, 0, 0, 1, 16'h0040);
    step(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0);
    ctl(0, 1, 1, 0, 16'h0000);
    step(1, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1, 0, 16'd0);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
